// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder slice.
package imem_pkg;

    // Responder control states: idle/accepting, counting down, delivering.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_t;

    // Word returned for a bad address; decodes as a harmless instruction.
    localparam logic [31:0] NOP_WORD = 32'h0;

    // Byte-offset bits below the word index in a fetch address.
    localparam int BYTE_OFFSET_BITS = 2;

    // Width of a word index into a memory of the given depth.
    function automatic int idxWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of the latency down-counter, never less than one bit.
    function automatic int cntWidth(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write port plus a registered read port
// that can substitute the NOP word when the request was a bad address.
module imem_array
    import imem_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 256,
    localparam int IW       = idxWidth(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrEn,
    input  logic [IW-1:0]        wrAddr,
    input  logic [WORD_SIZE-1:0] wrData,
    input  logic                 rdEn,
    input  logic [IW-1:0]        rdAddr,
    input  logic                 rdNop,
    output logic [WORD_SIZE-1:0] rdData
);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    // Program load: contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Registered read; a same-edge write to the same word is not seen (old data).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= rdNop ? WORD_SIZE'(NOP_WORD) : mem[rdAddr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Multi-cycle instruction-memory responder for the fetch stage. Holds the PC
// via freeze while a fetch is outstanding and abandons it on a branch flush.
module imem_responder
    import imem_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 3,
    localparam int IW       = idxWidth(DEPTH),
    localparam int CW       = cntWidth(LATENCY)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic                 flush,
    input  logic                 ld_en,
    input  logic [IW-1:0]        ld_addr,
    input  logic [WORD_SIZE-1:0] ld_data,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] instruction,
    output logic                 err,
    output logic                 freeze
);

    // The acceptance cycle is the first of the LATENCY freeze cycles, so WAIT
    // spans LATENCY-1 cycles and the counter starts one below that.
    localparam bit          DIRECT   = (LATENCY == 1);
    localparam logic [CW-1:0] LOAD_CNT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

    imem_state_t          state;
    logic [CW-1:0]        count;
    logic [IW-1:0]        idxCap;
    logic                 errCap;
    logic [IW-1:0]        reqIdx;
    logic                 reqErr;
    logic                 accept;
    logic                 waitDone;
    logic                 rdEn;
    logic [IW-1:0]        rdAddr;
    logic                 rdNop;

    assign reqIdx   = req_addr[IW+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS];
    assign reqErr   = (req_addr[BYTE_OFFSET_BITS-1:0] != '0)
                    | ((req_addr >> BYTE_OFFSET_BITS) >= WORD_SIZE'(DEPTH));
    assign accept   = (state == IDLE) & req_valid & ~flush;
    assign waitDone = (state == WAIT) & ~flush & (count == '0);

    // Memory is read on the edge that enters RESP, from the captured index.
    assign rdEn   = waitDone | (accept & DIRECT);
    assign rdAddr = waitDone ? idxCap : reqIdx;
    assign rdNop  = waitDone ? errCap : reqErr;

    // Fetch must hold the PC while accepting or waiting, but not on delivery.
    assign freeze = ~flush & (((state == IDLE) & req_valid) | (state == WAIT));

    // Fetch control: accept, count down the latency, deliver, then idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            idxCap     <= '0;
            errCap     <= 1'b0;
            resp_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        idxCap <= reqIdx;
                        errCap <= reqErr;
                        if (DIRECT) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            err        <= reqErr;
                        end else begin
                            state <= WAIT;
                            count <= LOAD_CNT;
                        end
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        err        <= errCap;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    imem_array #(
        .WORD_SIZE(WORD_SIZE),
        .DEPTH    (DEPTH)
    ) uArray (
        .clk   (clk),
        .rst   (rst),
        .wrEn  (ld_en),
        .wrAddr(ld_addr),
        .wrData(ld_data),
        .rdEn  (rdEn),
        .rdAddr(rdAddr),
        .rdNop (rdNop),
        .rdData(instruction)
    );

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with LATENCY=3, DEPTH=256.
module tb_imem_responder;

    localparam int WS  = 32;
    localparam int DP  = 256;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [WS-1:0] req_addr;
    logic          flush;
    logic          ld_en;
    logic [7:0]    ld_addr;
    logic [WS-1:0] ld_data;
    logic          resp_valid;
    logic [WS-1:0] instruction;
    logic          err;
    logic          freeze;

    int total = 0;
    int bad   = 0;

    imem_responder #(
        .WORD_SIZE(WS),
        .DEPTH    (DP),
        .LATENCY  (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .flush      (flush),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .resp_valid (resp_valid),
        .instruction(instruction),
        .err        (err),
        .freeze     (freeze)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic loadWord(input logic [7:0] addr, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // One full fetch: freeze for LAT cycles, then a one-cycle response, then hold.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] expInstr,
                                 input logic expErr, input string tag);
        req_valid = 1'b1;
        req_addr  = addr;
        for (int i = 0; i < LAT; i++) begin
            #1;
            checkOutput({tag, "_freeze"}, 32'(freeze), 32'd1);
            checkOutput({tag, "_noResp"}, 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        #1;
        checkOutput({tag, "_respValid"}, 32'(resp_valid), 32'd1);
        checkOutput({tag, "_instr"}, instruction, expInstr);
        checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
        checkOutput({tag, "_freezeLow"}, 32'(freeze), 32'd0);
        @(negedge clk);
        #1;
        checkOutput({tag, "_pulseEnd"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, "_instrHold"}, instruction, expInstr);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_respValid", 32'(resp_valid), 32'd0);
        checkOutput("rst_instr", instruction, 32'h0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_freeze", 32'(freeze), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Program load.
        loadWord(8'd5, 32'hDEADBEEF);
        loadWord(8'd6, 32'h66666666);
        loadWord(8'd0, 32'hAAAA0000);
        loadWord(8'd1, 32'h11111111);
        loadWord(8'd2, 32'h22222222);
        loadWord(8'd255, 32'hFFFF0001);

        // Basic fetch.
        applyStimulus(32'h14, 32'hDEADBEEF, 1'b0, "basic");
        req_valid = 1'b0;
        @(negedge clk);

        // Flush in the second WAIT cycle drops the fetch.
        req_valid = 1'b1;
        req_addr  = 32'h14;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checkOutput("flush_freeze", 32'(freeze), 32'd0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        checkOutput("flush_noResp", 32'(resp_valid), 32'd0);
        checkOutput("flush_idle", 32'(freeze), 32'd0);
        applyStimulus(32'h18, 32'h66666666, 1'b0, "flushNext");
        req_valid = 1'b0;
        @(negedge clk);

        // Bad addresses and the last valid word.
        applyStimulus(32'h15, 32'h0, 1'b1, "misalign");
        req_valid = 1'b0;
        @(negedge clk);
        applyStimulus(32'h400, 32'h0, 1'b1, "range");
        req_valid = 1'b0;
        @(negedge clk);
        applyStimulus(32'h3FC, 32'hFFFF0001, 1'b0, "lastWord");
        req_valid = 1'b0;
        @(negedge clk);

        // Back-to-back fetches, one response every LAT+1 cycles.
        applyStimulus(32'h0, 32'hAAAA0000, 1'b0, "b2b0");
        applyStimulus(32'h4, 32'h11111111, 1'b0, "b2b1");
        applyStimulus(32'h8, 32'h22222222, 1'b0, "b2b2");
        req_valid = 1'b0;
        @(negedge clk);

        // Load to word 5 on the same edge as its read: old data returned.
        req_valid = 1'b1;
        req_addr  = 32'h14;
        @(negedge clk);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 8'd5;
        ld_data = 32'hCAFEF00D;
        @(negedge clk);
        ld_en = 1'b0;
        #1;
        checkOutput("collide_respValid", 32'(resp_valid), 32'd1);
        checkOutput("collide_instr", instruction, 32'hDEADBEEF);
        req_valid = 1'b0;
        @(negedge clk);
        applyStimulus(32'h14, 32'hCAFEF00D, 1'b0, "afterLoad");
        req_valid = 1'b0;
        @(negedge clk);

        // Reset in the middle of a fetch.
        req_valid = 1'b1;
        req_addr  = 32'h14;
        @(negedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        checkOutput("midRst_respValid", 32'(resp_valid), 32'd0);
        checkOutput("midRst_instr", instruction, 32'h0);
        checkOutput("midRst_err", 32'(err), 32'd0);
        checkOutput("midRst_freeze", 32'(freeze), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("postRst_noResp", 32'(resp_valid), 32'd0);
        checkOutput("postRst_idle", 32'(freeze), 32'd0);
        applyStimulus(32'h14, 32'hCAFEF00D, 1'b0, "postReset");
        req_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
